// File: rtl/ldpc_llr_in_buf_if.sv
// LLR writer stream into ldpc_llr_in_buf: valid/ready beats with a frame-end marker.
interface ldpc_llr_in_buf_if #(
    parameter int ZC = 512,
    parameter int VW = 6
);
    logic             W_VALID;
    logic             W_READY;
    logic             W_LAST;
    logic [ZC*VW-1:0] W_DATA;

    modport master (output W_VALID, W_LAST, W_DATA, input W_READY);
    modport slave  (input W_VALID, W_LAST, W_DATA, output W_READY);
endinterface

// File: rtl/ldpc_llr_in_buf.sv
// LDPC input LLR frame buffer: collects one 32/24-beat frame and serves random beat reads to the core.
// Define LDPC_IN_PINGPONG_EN for two frame buffers (writer fills one while the core holds the other).
module ldpc_llr_in_buf #(
    parameter int ZC = 512,
    parameter int VW = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    ldpc_llr_in_buf_if.slave  w,
    output logic              frame_valid,
    output logic [1:0]        frame_mode,
    input  logic              core_rd_en,
    input  logic [4:0]        core_rd_addr,
    output logic [ZC*VW-1:0]  core_rd_data,
    input  logic              core_done,
    output logic              len_err
);
    localparam int BW = ZC * VW;
`ifdef LDPC_IN_PINGPONG_EN
    localparam int NB = 2;
    localparam int AW = 6;
`else
    localparam int NB = 1;
    localparam int AW = 5;
`endif
    localparam int FW = $clog2(NB + 1);

    typedef enum logic [1:0] {RECV, HOLD, FLUSH} state_e;

    state_e        state_q, state_d;
    logic [4:0]    wr_cnt_q, wr_cnt_d;
    logic [1:0]    lat_mode_q, lat_mode_d;
    logic [FW-1:0] full_q, full_d;
    logic          rdy_en_q, len_err_q, len_err_d;
    logic [BW-1:0] rd_data_q;
    logic [BW-1:0] mem [NB*32];
    logic [AW-1:0] wr_addr, rd_addr;
    logic [1:0]    cur_mode;
    logic [4:0]    n_last;
    logic          fire, wr_beat, fin, done, mode_ok;

    // Mode only matters on a frame's first beat; afterwards the latched copy rules.
    assign cur_mode     = (wr_cnt_q == 5'd0) ? mode : lat_mode_q;
    assign mode_ok      = (cur_mode == 2'd1) || (cur_mode == 2'd2);
    assign n_last       = (cur_mode == 2'd2) ? 5'd23 : 5'd31;
    assign w.W_READY    = rdy_en_q && ((state_q == FLUSH) || (state_q == RECV && mode_ok));
    assign fire         = w.W_VALID && w.W_READY;
    assign wr_beat      = fire && (state_q == RECV);
    assign fin          = wr_beat && w.W_LAST && (wr_cnt_q == n_last);
    assign frame_valid  = (full_q != '0);
    assign done         = core_done && frame_valid;
    assign core_rd_data = rd_data_q;
    assign len_err      = len_err_q;

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        lat_mode_d = lat_mode_q;
        full_d     = full_q;
        len_err_d  = 1'b0;
        if (wr_beat) begin
            lat_mode_d = cur_mode;
            if (w.W_LAST || wr_cnt_q == n_last) begin
                wr_cnt_d  = 5'd0;
                len_err_d = !fin;
                if (!w.W_LAST) state_d = FLUSH;
            end else begin
                wr_cnt_d = wr_cnt_q + 5'd1;
            end
        end
        if (state_q == FLUSH && fire && w.W_LAST) state_d = RECV;
        if (fin)  full_d = full_d + FW'(1);
        if (done) full_d = full_d - FW'(1);
        // Writer is blocked (HOLD) only when every buffer holds a frame.
        if (state_d != FLUSH) state_d = (full_d == FW'(NB)) ? HOLD : RECV;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RECV;
            wr_cnt_q   <= '0;
            lat_mode_q <= '0;
            full_q     <= '0;
            rdy_en_q   <= 1'b0;
            len_err_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            lat_mode_q <= lat_mode_d;
            full_q     <= full_d;
            rdy_en_q   <= 1'b1;
            len_err_q  <= len_err_d;
            if (core_rd_en && frame_valid) rd_data_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_beat) mem[wr_addr] <= w.W_DATA;
    end

`ifdef LDPC_IN_PINGPONG_EN
    logic       wr_buf_q, rd_buf_q;
    logic [1:0] fmode_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_buf_q   <= 1'b0;
            rd_buf_q   <= 1'b0;
            fmode_q[0] <= '0;
            fmode_q[1] <= '0;
        end else begin
            if (fin) begin
                fmode_q[wr_buf_q] <= lat_mode_q;
                wr_buf_q          <= !wr_buf_q;
            end
            if (done) rd_buf_q <= !rd_buf_q;
        end
    end

    assign wr_addr    = {wr_buf_q, wr_cnt_q};
    assign rd_addr    = {rd_buf_q, core_rd_addr};
    assign frame_mode = fmode_q[rd_buf_q];
`else
    logic [1:0] fmode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   fmode_q <= '0;
        else if (fin) fmode_q <= lat_mode_q;
    end

    assign wr_addr    = wr_cnt_q;
    assign rd_addr    = core_rd_addr;
    assign frame_mode = fmode_q;
`endif
endmodule

// File: tb/tb_ldpc_llr_in_buf.sv
// Scoreboard bench for ldpc_llr_in_buf: writer pushes expected frames/len_err cycles, monitors pop and compare.
module tb_ldpc_llr_in_buf;
  localparam int ZC = 512, VW = 6, BW = ZC * VW;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] mode = 2'd1;
  logic frame_valid, len_err;
  logic [1:0] frame_mode;
  logic core_rd_en = 1'b0, core_done = 1'b0;
  logic [4:0] core_rd_addr = '0;
  logic [BW-1:0] core_rd_data;

  int nvec = 0, nerr = 0, cyc = 0;
  bit writer_done = 1'b0, wr_abort = 1'b0;
  logic [1:0]    exp_m[$];
  logic [BW-1:0] exp_d[$];
  int            exp_err_q[$];

  ldpc_llr_in_buf_if #(.ZC(ZC), .VW(VW)) w ();
  ldpc_llr_in_buf #(.ZC(ZC), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .w(w),
    .frame_valid(frame_valid), .frame_mode(frame_mode),
    .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data),
    .core_done(core_done), .len_err(len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input int a, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s beat %0d: got 0x%h, expected 0x%h (low 64 bits)", nm, a, act[63:0], exp[63:0]);
    end
  endtask

  task automatic fail_now(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [BW-1:0] rnd_beat();
    logic [BW-1:0] v;
    for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic int frame_len(input logic [1:0] m);
    return (m == 2'd2) ? 24 : 32;
  endfunction

  // One beat: optional idle gap, then hold valid until accepted; k = cycle of the accepting edge.
  task automatic send_beat(input logic [BW-1:0] d, input bit last, input bit gap, output int k);
    int t = 0;
    k = -1;
    @(negedge clk);
    if (gap && $urandom_range(0, 3) == 0) begin
      w.W_VALID = 1'b0;
      @(negedge clk);
    end
    w.W_VALID = 1'b1; w.W_LAST = last; w.W_DATA = d;
    #1;
    while (!w.W_READY && t < 200) begin
      @(negedge clk); #1; t++;
    end
    if (!w.W_READY) begin
      fail_now("w_ready_timeout");
      wr_abort = 1'b1;
      w.W_VALID = 1'b0;
      return;
    end
    @(posedge clk); #1;
    k = cyc;
  endtask

  // Frame-level reference: exactly N beats -> held frame; otherwise one len_err, nothing held.
  task automatic send_frame(input logic [1:0] m, input int len, input bit rnd);
    logic [BW-1:0] bts [40];
    int n, eb, k;
    n  = frame_len(m);
    eb = (len < n) ? len - 1 : n - 1;
    for (int b = 0; b < len; b++) bts[b] = rnd ? rnd_beat() : BW'(b);
    if (len == n) begin
      exp_m.push_back(m);
      for (int b = 0; b < n; b++) exp_d.push_back(bts[b]);
    end
    mode = m;
    for (int b = 0; b < len; b++) begin
      if (wr_abort) return;
      send_beat(bts[b], b == len - 1, rnd, k);
      if (wr_abort) return;
      if (rnd && b == 0 && $urandom_range(0, 1) == 1) mode = 2'd3 - m;
      if (len != n && b == eb) exp_err_q.push_back(k);
    end
  endtask

  task automatic writer();
    logic [1:0] m;
    int len;
    send_frame(2'd1, 32, 1'b0);
    send_frame(2'd2, 24, 1'b0);
    send_frame(2'd1, 21, 1'b0);
    send_frame(2'd1, 32, 1'b0);
    send_frame(2'd2, 30, 1'b0);
    send_frame(2'd2, 24, 1'b1);
    repeat (14) begin
      m   = 2'($urandom_range(1, 2));
      len = ($urandom_range(0, 9) < 7) ? frame_len(m) : int'($urandom_range(1, 40));
      send_frame(m, len, 1'b1);
    end
    w.W_VALID = 1'b0;
    writer_done = 1'b1;
  endtask

  // Core side: on each held frame, check mode and random beat reads, then release it.
  task automatic core_loop();
    logic [BW-1:0] fd [32];
    logic [1:0] m;
    int n, a, idle = 0;
    while (!(writer_done && exp_m.size() == 0)) begin
      @(negedge clk);
      if (!frame_valid) begin
        idle++;
        if (idle > 500) begin fail_now("frame_valid_timeout"); return; end
        continue;
      end
      idle = 0;
      if (exp_m.size() == 0) begin
        fail_now("unexpected_frame");
        core_done = 1'b1; @(negedge clk); core_done = 1'b0;
        continue;
      end
      m = exp_m.pop_front();
      n = frame_len(m);
      for (int b = 0; b < n; b++) fd[b] = exp_d.pop_front();
      chk("frame_mode", 64'(frame_mode), 64'(m));
`ifndef LDPC_IN_PINGPONG_EN
      chk("w_ready_in_hold", 64'(w.W_READY), 64'd0);
`endif
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = 0;
      for (int r = 0; r < 6; r++) begin
        a = (r == 0) ? 0 : (r == 1) ? n - 1 : (r == 2) ? 17 : int'($urandom_range(0, n - 1));
        core_rd_en = 1'b1; core_rd_addr = 5'(a);
        @(negedge clk);
        core_rd_en = 1'b0;
        chkw("rd_data", a, core_rd_data, fd[a]);
      end
      core_rd_addr = 5'(~a);
      @(negedge clk);
      chkw("rd_hold", a, core_rd_data, fd[a]);
      core_done = 1'b1; @(negedge clk); core_done = 1'b0;
`ifndef LDPC_IN_PINGPONG_EN
      chk("fv_after_done", 64'(frame_valid), 64'd0);
      chk("w_ready_after_done", 64'(w.W_READY), 64'd1);
`endif
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (len_err === 1'b1) begin
      if (exp_err_q.size() == 0) fail_now("len_err_unexpected");
      else chk("len_err_cycle", 64'(cyc), 64'(exp_err_q.pop_front()));
    end
  end

  initial begin
    int k;
    w.W_VALID = 1'b0; w.W_LAST = 1'b0; w.W_DATA = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_w_ready", 64'(w.W_READY), 64'd0);
    chk("rst_frame_valid", 64'(frame_valid), 64'd0);
    chk("rst_frame_mode", 64'(frame_mode), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chkw("rst_rd_data", 0, core_rd_data, '0);
    @(negedge clk); rst_n = 1'b1; mode = 2'd1;
    #1 chk("ready_before_first_edge", 64'(w.W_READY), 64'd0);
    @(negedge clk);
    #1 chk("ready_mode1", 64'(w.W_READY), 64'd1);
    mode = 2'd0; #1 chk("ready_mode0", 64'(w.W_READY), 64'd0);
    mode = 2'd3; #1 chk("ready_mode3", 64'(w.W_READY), 64'd0);
    mode = 2'd2; #1 chk("ready_mode2", 64'(w.W_READY), 64'd1);
    // Reads and releases with nothing held must do nothing.
    @(negedge clk); core_rd_en = 1'b1; core_rd_addr = 5'd5; core_done = 1'b1;
    @(negedge clk); core_rd_en = 1'b0; core_done = 1'b0;
    chkw("rd_ignored_idle", 5, core_rd_data, '0);
    chk("fv_idle", 64'(frame_valid), 64'd0);
    // Full mode-2 frame, then reset while it is held.
    mode = 2'd2;
    for (int b = 0; b < 24; b++) send_beat(BW'(b), b == 23, 1'b0, k);
    w.W_VALID = 1'b0;
    @(negedge clk);
    chk("hold_fv", 64'(frame_valid), 64'd1);
    chk("hold_mode", 64'(frame_mode), 64'd2);
`ifndef LDPC_IN_PINGPONG_EN
    chk("hold_ready", 64'(w.W_READY), 64'd0);
`endif
    core_rd_en = 1'b1; core_rd_addr = 5'd5;
    @(negedge clk); core_rd_en = 1'b0;
    chkw("hold_rd", 5, core_rd_data, BW'(5));
    rst_n = 1'b0;
    #1;
    chk("rst_hold_fv", 64'(frame_valid), 64'd0);
    chk("rst_hold_ready", 64'(w.W_READY), 64'd0);
    chk("rst_hold_mode", 64'(frame_mode), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    // Reset in the middle of a frame; the partial frame must vanish.
    mode = 2'd1;
    for (int b = 0; b < 10; b++) send_beat(rnd_beat(), 1'b0, 1'b0, k);
    w.W_VALID = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(w.W_READY), 64'd0);
    chk("rst_mid_fv", 64'(frame_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    fork
      writer();
      core_loop();
    join
    repeat (4) @(negedge clk);
    chk("len_err_all_seen", 64'(exp_err_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
